// File: rtl/gpr_if.sv
// Register-file port bundle: decode-side reads/issue and writeback write port.
// Signal names follow the core's register-file pin names.
interface gpr_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] RADDR;
  logic [NUM_RD*DATA_W-1:0] RDATA;
  logic [NUM_RD-1:0]        RBUSY;
  logic                     WE;
  logic [ADDR_W-1:0]        WADDR;
  logic [DATA_W-1:0]        WDATA;
  logic                     ISSUE;
  logic [ADDR_W-1:0]        ISSUE_ADDR;
  logic [ADDR_W:0]          PEND_CNT;

  modport master (
    output RADDR, WE, WADDR, WDATA, ISSUE, ISSUE_ADDR,
    input  RDATA, RBUSY, PEND_CNT
  );

  modport slave (
    input  RADDR, WE, WADDR, WDATA, ISSUE, ISSUE_ADDR,
    output RDATA, RBUSY, PEND_CNT
  );
endinterface

// File: rtl/gpr_file.sv
// General-purpose register file with r0 hardwired to zero, per-register pending bits and a
// pending counter. Optional same-cycle write-to-read bypass enabled by defining GPR_BYPASS_EN.
module gpr_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic  CLK,
  input  logic  RST,
  gpr_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DEPTH-1:0]         pend_q, pend_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     we_v, iss_v, same_w;
  logic                     set_new, clr_old;
  logic [NUM_RD*DATA_W-1:0] rdata_w;
  logic [NUM_RD-1:0]        rbusy_w;

  assign we_v   = bus.WE && (bus.WADDR != '0);
  assign iss_v  = bus.ISSUE && (bus.ISSUE_ADDR != '0);
  assign same_w = iss_v && (bus.ISSUE_ADDR == bus.WADDR);

  // Counter moves only on real transitions; a collision on one register leaves it set.
  assign set_new = iss_v && !pend_q[bus.ISSUE_ADDR];
  assign clr_old = we_v && pend_q[bus.WADDR] && !same_w;
  assign cnt_d   = cnt_q + CNT_W'(set_new) - CNT_W'(clr_old);

  always_comb begin
    pend_d = pend_q;
    if (we_v)  pend_d[bus.WADDR]      = 1'b0;
    if (iss_v) pend_d[bus.ISSUE_ADDR] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (we_v) mem_q[bus.WADDR] <= bus.WDATA;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              byp;
    assign ra = bus.RADDR[k*ADDR_W +: ADDR_W];
`ifdef GPR_BYPASS_EN
    assign byp = we_v && (ra == bus.WADDR);
`else
    assign byp = 1'b0;
`endif
    // A bypassed write hides the pending bit unless a new producer claims the register.
    assign rdata_w[k*DATA_W +: DATA_W] = byp ? bus.WDATA :
                                         (ra == '0) ? '0 : mem_q[ra];
    assign rbusy_w[k] = pend_q[ra] & ~(byp & ~same_w);
  end

  assign bus.RDATA    = rdata_w;
  assign bus.RBUSY    = rbusy_w;
  assign bus.PEND_CNT = cnt_q;

endmodule
